// File: rtl/sub_pkg.sv
// sub_pkg
// Shared definitions for the bit-serial subtract/complement controller.
//   OP_*     : operation codes as presented on the op input
//   state_t  : controller state encoding (2-bit binary, IDLE = 00)
//   decode_op: folds the reserved op code 11 onto plain subtraction
package sub_pkg;

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_ONES = 2'b01;
    localparam logic [1:0] OP_TWOS = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // op 11 behaves exactly like A-B, so it is collapsed at capture time
    // and the datapath only ever sees the three real operations.
    function automatic logic [1:0] decode_op(input logic [1:0] op);
        return (op == 2'b11) ? OP_SUB : op;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if
// Request/result bundle between the operand switches and the controller.
//   start  : request, sampled only while the controller is idle
//   op     : operation code (see sub_pkg)
//   a, b   : operands, captured on the accepted start
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when y/borrow have just been updated
//   y      : result register, held until the next done
//   borrow : final borrow-out, updated together with y
//   state  : controller state, exported for observation
// Handshake: a start is accepted only on a rising edge where the controller
// is idle and start=1; the matching result is valid from the cycle done=1
// and stays valid until the next done. Starts at any other time are dropped.
// Modports: master drives the request side, slave is the controller.
import sub_pkg::*;

interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             borrow;
    state_t           state;

    modport master (
        output start, op, a, b,
        input  busy, done, y, borrow, state
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, y, borrow, state
    );
endinterface

// File: rtl/full_sub.sv
// full_sub
// Combinational one-bit full subtractor computing a - b - bin.
//   a, b : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Bit-serial controller that runs one shared full subtractor over WIDTH
// cycles, LSB first, to produce A-B, ~A or 0-A.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_sub_ctrl_if (start/op/a/b in,
//           busy/done/y/borrow/state out)
// Timing: start accepted on edge k -> busy after k, bits on k+1..k+WIDTH,
// done/y/borrow after k+WIDTH, back in IDLE after k+WIDTH+1.
import sub_pkg::*;

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_sub_ctrl_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [1:0]       op_r;
    logic             bchain;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] y_r;
    logic             borrow_r;

    logic cell_a;
    logic cell_b;
    logic cell_bin;
    logic cell_d;
    logic cell_bout;

    // Operand steering for the shared bit cell. Two's complement is 0 - A;
    // ones complement is 1 - A with the borrow chain cut, giving ~A[i].
    always_comb begin
        cell_a   = a_sr[0];
        cell_b   = b_sr[0];
        cell_bin = bchain;
        case (op_r)
            OP_ONES: begin
                cell_a   = 1'b1;
                cell_b   = a_sr[0];
                cell_bin = 1'b0;
            end
            OP_TWOS: begin
                cell_a   = 1'b0;
                cell_b   = a_sr[0];
            end
            default: begin
                cell_a   = a_sr[0];
                cell_b   = b_sr[0];
            end
        endcase
    end

    full_sub u_cell (
        .a    (cell_a),
        .b    (cell_b),
        .bin  (cell_bin),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            op_r     <= OP_SUB;
            bchain   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            y_r      <= '0;
            borrow_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        op_r   <= decode_op(bus.op);
                        cnt    <= '0;
                        bchain <= 1'b0;
                        res_sr <= '0;
                        busy_r <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Difference bits enter from the MSB side so that after
                    // WIDTH shifts bit 0 has arrived at the LSB.
                    res_sr <= {cell_d, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    bchain <= cell_bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Result is published on the edge that enters DONE
                        // so y/borrow are valid in the same cycle as done.
                        y_r      <= {cell_d, res_sr[WIDTH-1:1]};
                        borrow_r <= cell_bout;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.y      = y_r;
    assign bus.borrow = borrow_r;
    assign bus.state  = state;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl
// Directed bench for serial_sub_ctrl at WIDTH=8: reset values, a vector
// table of operations, ignored starts, and reset in the middle of a run.
import sub_pkg::*;

module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    serial_sub_ctrl_if #(.WIDTH(W)) bus ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_y;
        logic         exp_br;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request and follow it to its done pulse (bounded).
    // Operand inputs are scrambled after capture to show they are ignored.
    task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, output logic [W-1:0] y_o,
                          output logic br_o, output int busy_n, output int lat,
                          output bit seen, output bit overlap);
        @(negedge clk);
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_n  = 0;
        lat     = 0;
        seen    = 1'b0;
        overlap = 1'b0;
        y_o     = '0;
        br_o    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            lat++;
            if (bus.busy) busy_n++;
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.done) begin
                seen = 1'b1;
                y_o  = bus.y;
                br_o = bus.borrow;
            end else begin
                bus.a  = W'($urandom_range(0, 255));
                bus.b  = W'($urandom_range(0, 255));
                bus.op = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
        end
    endtask

    logic [W-1:0] ry;
    logic         rbr;
    int           rbusy;
    int           rlat;
    bit           rseen;
    bit           rovl;
    int           dones;

    initial begin
        vecs[0]  = '{OP_SUB,  8'h5A, 8'h23, 8'h37, 1'b0};
        vecs[1]  = '{OP_SUB,  8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[2]  = '{OP_SUB,  8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[3]  = '{OP_TWOS, 8'h01, 8'h00, 8'hFF, 1'b1};
        vecs[4]  = '{OP_TWOS, 8'h00, 8'h77, 8'h00, 1'b0};
        vecs[5]  = '{OP_ONES, 8'hA5, 8'hFF, 8'h5A, 1'b0};
        vecs[6]  = '{2'b11,   8'h05, 8'h03, 8'h02, 1'b0};
        vecs[7]  = '{OP_SUB,  8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[8]  = '{OP_TWOS, 8'h80, 8'h12, 8'h80, 1'b1};
        vecs[9]  = '{OP_ONES, 8'h00, 8'h33, 8'hFF, 1'b0};
        vecs[10] = '{2'b11,   8'h03, 8'h05, 8'hFE, 1'b1};

        // reset values
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_y",      32'(bus.y), 32'h0);
        check("rst_borrow", 32'(bus.borrow), 32'h0);
        check("rst_busy",   32'(bus.busy), 32'h0);
        check("rst_done",   32'(bus.done), 32'h0);
        check("rst_state",  32'(bus.state), 32'(S_IDLE));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_hold", {bus.y, 22'h0, bus.borrow, bus.busy, bus.done},
                  32'h0);
        end

        // vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, ry, rbr, rbusy, rlat, rseen, rovl);
            check($sformatf("v%0d_done_seen", i), 32'(rseen), 32'h1);
            check($sformatf("v%0d_y", i),         32'(ry), 32'(vecs[i].exp_y));
            check($sformatf("v%0d_borrow", i),    32'(rbr), 32'(vecs[i].exp_br));
            check($sformatf("v%0d_busy_cycles", i), 32'(rbusy), 32'(W));
            check($sformatf("v%0d_latency", i),   32'(rlat), 32'(W + 1));
            check($sformatf("v%0d_busy_done_overlap", i), 32'(rovl), 32'h0);
            @(negedge clk);
            check($sformatf("v%0d_done_width", i), 32'(bus.done), 32'h0);
            check($sformatf("v%0d_idle", i),      32'(bus.state), 32'(S_IDLE));
            check($sformatf("v%0d_y_held", i),    32'(bus.y), 32'(vecs[i].exp_y));
        end

        // starts during SHIFT and DONE are dropped
        @(negedge clk);
        bus.op = OP_SUB; bus.a = 8'h5A; bus.b = 8'h23; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        rseen = 1'b0;
        for (int i = 0; i < 40 && !rseen; i++) begin
            if (i == 3) begin
                bus.op = OP_ONES; bus.a = 8'hFF; bus.b = 8'h00; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                rseen = 1'b1;
                rlat  = i + 1;
            end else begin
                @(negedge clk);
            end
        end
        check("ign_done_seen", 32'(rseen), 32'h1);
        check("ign_latency",   32'(rlat), 32'(W + 1));
        check("ign_y",         32'(bus.y), 32'h37);
        check("ign_borrow",    32'(bus.borrow), 32'h0);
        bus.start = 1'b1;  // presented while in DONE
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_idle_after_done", 32'(bus.state), 32'(S_IDLE));
        check("ign_no_busy",         32'(bus.busy), 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("ign_extra_done", 32'(dones), 32'h0);
        check("ign_y_kept",     32'(bus.y), 32'h37);

        // reset in the middle of an operation
        @(negedge clk);
        bus.op = OP_SUB; bus.a = 8'h10; bus.b = 8'h20; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_busy", 32'(bus.busy), 32'h1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_y",      32'(bus.y), 32'h0);
        check("mid_rst_borrow", 32'(bus.borrow), 32'h0);
        check("mid_rst_busy",   32'(bus.busy), 32'h0);
        check("mid_rst_done",   32'(bus.done), 32'h0);
        check("mid_rst_state",  32'(bus.state), 32'(S_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("mid_no_done", 32'(dones), 32'h0);
        run_op(OP_SUB, 8'h80, 8'h01, ry, rbr, rbusy, rlat, rseen, rovl);
        check("post_rst_seen",    32'(rseen), 32'h1);
        check("post_rst_y",       32'(ry), 32'h7F);
        check("post_rst_borrow",  32'(rbr), 32'h0);
        check("post_rst_latency", 32'(rlat), 32'(W + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
